// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencer for one butterfly unit running a full 256-point Kyber NTT/INTT (7 layers x 128 butterflies).
// Latency: first read 1 cycle after start is accepted; done pulses 7*(128+RD_LAT+BF_LAT)+1 cycles after start.
// Backpressure: none; one butterfly per cycle in RUN, start is ignored while busy.
//
// Ports:
//   clk, rst (sync, active-low)        - clock and reset
//   start, inv                         - job request and job type (0 NTT, 1 INTT), sampled in IDLE
//   busy, done, layer, bf_mode         - job status and butterfly mode (11 when idle)
//   rd_en, rd_addr_a/b, tw_addr        - coefficient-pair read and zeta-ROM index
//   wr_en, wr_addr_a/b                 - write-back, the read tuple delayed by RD_LAT+BF_LAT
module ntt_ctrl #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic [2:0] layer,
  output logic [1:0] bf_mode,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  // Pipeline depth from read issue to write-back.
  localparam int P  = RD_LAT + BF_LAT;
  localparam int CW = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [6:0]    i_q, i_d;
  logic [2:0]    layer_q, layer_d;
  logic          inv_q, inv_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      layer_q <= '0;
      inv_q   <= 1'b0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      layer_q <= layer_d;
      inv_q   <= inv_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    layer_d = layer_q;
    inv_d   = inv_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          inv_d   = inv;
          layer_d = '0;
          i_d     = '0;
        end
      end
      S_RUN: begin
        if (i_q == 7'd127) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          i_d = i_q + 7'd1;
        end
      end
      S_DRAIN: begin
        // Hold off the next layer until the last write of this layer has landed.
        if (drain_q == CW'(P - 1)) begin
          i_d = '0;
          if (layer_q == 3'd6) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = S_RUN;
          end
        end else begin
          drain_d = drain_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address generation. log2(len) is constant per layer, so group/offset are a
  // shift and a mask: a = 2*len*g + o equals ((i & ~mask) << 1) | (i & mask).
  logic [2:0] shamt;
  logic [7:0] len, mask, i_ext, grp, addr_a, addr_b, tw_full;
  logic       run;

  always_comb begin
    shamt   = inv_q ? (layer_q + 3'd1) : (3'd7 - layer_q);
    len     = 8'd1 << shamt;
    mask    = len - 8'd1;
    i_ext   = {1'b0, i_q};
    grp     = i_ext >> shamt;
    addr_a  = ((i_ext & ~mask) << 1) | (i_ext & mask);
    addr_b  = addr_a + len;
    // NTT walks the zeta table upward from 1<<l; INTT walks it downward.
    tw_full = inv_q ? ((8'd128 >> layer_q) - 8'd1 - grp) : ((8'd1 << layer_q) + grp);
    run     = (state_q == S_RUN);
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign layer     = layer_q;
  // Mode is held through DRAIN so in-flight butterflies finish in the job's mode.
  assign bf_mode   = busy ? {1'b0, inv_q} : 2'b11;
  assign rd_en     = run;
  assign rd_addr_a = run ? addr_a : 8'd0;
  assign rd_addr_b = run ? addr_b : 8'd0;
  assign tw_addr   = run ? tw_full[6:0] : 7'd0;

  // Write-back delay line; clearing it on reset drops writes for in-flight reads.
  logic [P-1:0] wv_q;
  logic [7:0]   wa_q [P];
  logic [7:0]   wb_q [P];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wv_q <= '0;
      for (int k = 0; k < P; k++) begin
        wa_q[k] <= 8'd0;
        wb_q[k] <= 8'd0;
      end
    end else begin
      wv_q[0] <= rd_en;
      wa_q[0] <= rd_addr_a;
      wb_q[0] <= rd_addr_b;
      for (int k = 1; k < P; k++) begin
        wv_q[k] <= wv_q[k-1];
        wa_q[k] <= wa_q[k-1];
        wb_q[k] <= wb_q[k-1];
      end
    end
  end

  assign wr_en     = wv_q[P-1];
  assign wr_addr_a = wa_q[P-1];
  assign wr_addr_b = wb_q[P-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: scoreboard bench for ntt_ctrl with default latencies (P = 4).
// Issuing a job pushes the expected read/write/done stream; a negedge monitor pops and compares.
// Directed scenarios: NTT, INTT, start while busy, reset mid-job, back-to-back jobs.
module tb_ntt_ctrl;

  localparam int P      = 4;
  localparam int LSTEP  = 128 + P;
  localparam int JOBLEN = 7 * LSTEP;   // done lands in job cycle JOBLEN+1

  logic       clk = 1'b0;
  logic       rst, start, inv;
  logic       busy, done, rd_en, wr_en;
  logic [2:0] layer;
  logic [1:0] bf_mode;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] tw_addr;

  ntt_ctrl #(.RD_LAT(1), .BF_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .busy(busy), .done(done), .layer(layer), .bf_mode(bf_mode),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  // cyc == E at the negedge following posedge number E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int l; int a; int b; int tw;} exp_t;
  exp_t rq[$];
  exp_t wq[$];
  exp_t sq[$];
  int   dq[$];

  int checks = 0;
  int errors = 0;
  int job_lo = 0, job_hi = -1, job_base = 0;
  bit job_inv = 1'b0;
  int rd_cnt = 0, wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected/observed (cyc %0d)", name, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   eb;
    eb = (cyc >= job_lo && cyc <= job_hi) ? 1 : 0;
    chk("busy", busy, eb);
    chk("bf_mode", bf_mode, (eb != 0) ? {30'd0, 1'b0, job_inv} : 32'd3);
    if (rd_en === 1'b1) begin
      rd_cnt++;
      if (rq.size() == 0) fail("rd_unexpected");
      else begin
        e = rq.pop_front();
        chk("rd_cycle", cyc, e.c);
        chk("rd_layer", layer, e.l);
        chk("rd_addr_a", rd_addr_a, e.a);
        chk("rd_addr_b", rd_addr_b, e.b);
        chk("tw_addr", tw_addr, e.tw);
      end
    end
    if (wr_en === 1'b1) begin
      wr_cnt++;
      if (wq.size() == 0) fail("wr_unexpected");
      else begin
        e = wq.pop_front();
        chk("wr_cycle", cyc, e.c);
        chk("wr_addr_a", wr_addr_a, e.a);
        chk("wr_addr_b", wr_addr_b, e.b);
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) fail("done_unexpected");
      else chk("done_cycle", cyc, dq.pop_front());
    end
    if (sq.size() > 0 && cyc >= sq[0].c) begin
      e = sq.pop_front();
      chk("spot_cycle", cyc, e.c);
      chk("spot_rd_en", rd_en, 1);
      chk("spot_layer", layer, e.l);
      chk("spot_a", rd_addr_a, e.a);
      chk("spot_b", rd_addr_b, e.b);
      chk("spot_tw", tw_addr, e.tw);
    end
  end

  task automatic push_spot(input int b, input int k, input int l, input int a, input int bb, input int tw);
    sq.push_back('{b + k - 1, l, a, bb, tw});
  endtask

  // Called at a negedge; start is sampled by the next posedge (job cycle 1 follows it).
  task automatic issue(input bit jinv);
    int b, len, g, o, a, bb, tw, kc;
    b = cyc + 1;
    for (int l = 0; l < 7; l++) begin
      for (int i = 0; i < 128; i++) begin
        len = jinv ? (2 << l) : (128 >> l);
        g   = i / len;
        o   = i % len;
        a   = 2 * len * g + o;
        bb  = a + len;
        tw  = jinv ? ((128 >> l) - 1 - g) : ((1 << l) + g);
        kc  = 1 + l * LSTEP + i;
        rq.push_back('{b + kc - 1, l, a, bb, tw});
        wq.push_back('{b + kc - 1 + P, l, a, bb, 0});
      end
    end
    dq.push_back(b + JOBLEN);
    if (!jinv) begin
      push_spot(b, 1,   0, 0,   128, 1);
      push_spot(b, 2,   0, 1,   129, 1);
      push_spot(b, 197, 1, 128, 192, 3);
      push_spot(b, 793, 6, 0,   2,   64);
      push_spot(b, 794, 6, 1,   3,   64);
      push_spot(b, 795, 6, 4,   6,   65);
    end else begin
      push_spot(b, 1,   0, 0, 2,   127);
      push_spot(b, 2,   0, 1, 3,   127);
      push_spot(b, 3,   0, 4, 6,   126);
      push_spot(b, 793, 6, 0, 128, 1);
    end
    job_base = b;
    job_lo   = b;
    job_hi   = b + JOBLEN - 1;
    job_inv  = jinv;
    rd_cnt   = 0;
    wr_cnt   = 0;
    start    = 1'b1;
    inv      = jinv;
    @(negedge clk);
    start    = 1'b0;
    inv      = ~jinv;   // latched inv must not follow the pin
  endtask

  task automatic wait_job_cycle(input int k);
    while (cyc < job_base + k - 1) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) fail("done_timeout");
    chk("rd_pulses", rd_cnt, 896);
    chk("wr_pulses", wr_cnt, 896);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_a"}, rd_addr_a, 0);
    chk({tag, "_rd_b"}, rd_addr_b, 0);
    chk({tag, "_wr_a"}, wr_addr_a, 0);
    chk({tag, "_wr_b"}, wr_addr_b, 0);
    chk({tag, "_tw"}, tw_addr, 0);
    chk({tag, "_layer"}, layer, 0);
    chk({tag, "_bf_mode"}, bf_mode, 3);
  endtask

  task automatic clear_job();
    rq.delete();
    wq.delete();
    sq.delete();
    dq.delete();
    job_lo = 0;
    job_hi = -1;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    inv   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("init");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Forward NTT.
    issue(1'b0);
    wait_done();
    repeat (3) @(negedge clk);

    // Inverse NTT.
    issue(1'b1);
    wait_done();
    repeat (3) @(negedge clk);

    // Start requests while busy (with inv flipped) must be ignored.
    issue(1'b0);
    wait_job_cycle(10);
    start = 1'b1; inv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_job_cycle(500);
    start = 1'b1; inv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Reset during layer 3 (reads of layer 3 occupy job cycles 397..524).
    issue(1'b0);
    wait_job_cycle(447);
    rst = 1'b0;
    @(posedge clk);
    clear_job();
    @(negedge clk);
    check_reset("midjob");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Fresh job after reset, then a second job started in the done cycle.
    issue(1'b0);
    wait_done();
    issue(1'b0);
    wait_done();
    repeat (6) @(negedge clk);

    chk("rq_left", rq.size(), 0);
    chk("wq_left", wq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("sq_left", sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
